// File: rtl/decode_stage.sv
// decode_stage: IF/ID register, regfile read addressing, writeback bypass, load-use stall, ID/EX register
module decode_stage #(
  parameter logic [3:0] LOAD_OP = 4'h8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_VALID,
  input  logic [15:0] IF_INSTR,
  input  logic [15:0] IF_PC,
  output logic        IF_READY,
  input  logic        FLUSH,
  output logic [3:0]  RS1,
  output logic [3:0]  RS2,
  input  logic [15:0] REG_A,
  input  logic [15:0] REG_B,
  input  logic [3:0]  WB_RD,
  input  logic [15:0] WB_DATA,
  input  logic        WB_REGWRITE,
  output logic        STALL,
  output logic        EX_VALID,
  output logic [3:0]  EX_OPCODE,
  output logic [3:0]  EX_RD,
  output logic [3:0]  EX_RS1,
  output logic [3:0]  EX_RS2,
  output logic [15:0] EX_A,
  output logic [15:0] EX_B,
  output logic [15:0] EX_IMM,
  output logic [15:0] EX_PC
);
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] op_a;
  logic [15:0] op_b;
  // read addresses, hazard detect and same-cycle writeback forwarding
  always_comb begin
    RS1      = id_instr[7:4];
    RS2      = id_instr[3:0];
    STALL    = id_valid && EX_VALID && EX_OPCODE == LOAD_OP && (EX_RD == RS1 || EX_RD == RS2);
    IF_READY = !STALL;
    op_a     = (WB_REGWRITE && WB_RD == RS1) ? WB_DATA : REG_A;
    op_b     = (WB_REGWRITE && WB_RD == RS2) ? WB_DATA : REG_B;
  end
  // IF/ID register: squashed by flush, frozen by stall
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (FLUSH) begin
      id_valid <= 1'b0;
    end else if (!STALL) begin
      id_valid <= IF_VALID;
      id_instr <= IF_INSTR;
      id_pc    <= IF_PC;
    end
  end
  // ID/EX register: bubble on flush, stall or empty ID; payload only moves with a real instruction
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      EX_VALID  <= 1'b0;
      EX_OPCODE <= '0;
      EX_RD     <= '0;
      EX_RS1    <= '0;
      EX_RS2    <= '0;
      EX_A      <= '0;
      EX_B      <= '0;
      EX_IMM    <= '0;
      EX_PC     <= '0;
    end else if (FLUSH || STALL || !id_valid) begin
      EX_VALID <= 1'b0;
    end else begin
      EX_VALID  <= 1'b1;
      EX_OPCODE <= id_instr[15:12];
      EX_RD     <= id_instr[11:8];
      EX_RS1    <= RS1;
      EX_RS2    <= RS2;
      EX_A      <= op_a;
      EX_B      <= op_b;
      EX_IMM    <= {{8{id_instr[7]}}, id_instr[7:0]};
      EX_PC     <= id_pc;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage
module tb_decode_stage;
  logic        CLK = 0;
  logic        RST = 1;
  logic        IF_VALID = 0;
  logic [15:0] IF_INSTR = '0;
  logic [15:0] IF_PC = '0;
  logic        IF_READY;
  logic        FLUSH = 0;
  logic [3:0]  RS1, RS2;
  logic [15:0] REG_A = '0;
  logic [15:0] REG_B = '0;
  logic [3:0]  WB_RD = '0;
  logic [15:0] WB_DATA = '0;
  logic        WB_REGWRITE = 0;
  logic        STALL, EX_VALID;
  logic [3:0]  EX_OPCODE, EX_RD, EX_RS1, EX_RS2;
  logic [15:0] EX_A, EX_B, EX_IMM, EX_PC;
  logic [79:0] ex_pl;
  logic [79:0] sb[$];
  int          errors = 0;
  int          checks = 0;

  decode_stage dut (
    .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IF_INSTR(IF_INSTR), .IF_PC(IF_PC),
    .IF_READY(IF_READY), .FLUSH(FLUSH), .RS1(RS1), .RS2(RS2), .REG_A(REG_A), .REG_B(REG_B),
    .WB_RD(WB_RD), .WB_DATA(WB_DATA), .WB_REGWRITE(WB_REGWRITE), .STALL(STALL),
    .EX_VALID(EX_VALID), .EX_OPCODE(EX_OPCODE), .EX_RD(EX_RD), .EX_RS1(EX_RS1),
    .EX_RS2(EX_RS2), .EX_A(EX_A), .EX_B(EX_B), .EX_IMM(EX_IMM), .EX_PC(EX_PC)
  );

  always #5 CLK = ~CLK;

  assign ex_pl = {EX_OPCODE, EX_RD, EX_RS1, EX_RS2, EX_A, EX_B, EX_IMM, EX_PC};

  function automatic logic [79:0] ex_of(logic [15:0] ins, logic [15:0] pc, logic [15:0] a, logic [15:0] b);
    return {ins[15:12], ins[11:8], ins[7:4], ins[3:0], a, b, {{8{ins[7]}}, ins[7:0]}, pc};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [15:0] ins, input logic [15:0] pc);
    IF_VALID = 1;
    IF_INSTR = ins;
    IF_PC    = pc;
  endtask

  task automatic tick(input logic ev);
    logic [79:0] e;
    @(posedge CLK);
    @(negedge CLK);
    chk("ex_valid", 80'(EX_VALID), 80'(ev));
    if (ev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow observed=%h expected=none", ex_pl);
      end else begin
        e = sb.pop_front();
        chk("ex_payload", ex_pl, e);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_ex_valid", 80'(EX_VALID), 80'(0));
    chk("rst_payload", ex_pl, 80'(0));
    chk("rst_stall", 80'({STALL, IF_READY}), 80'(2'b01));
    RST = 0;
    REG_A = 16'h00AA;
    REG_B = 16'h00BB;
    // streaming
    present(16'h1123, 16'h0010);
    sb.push_back(ex_of(16'h1123, 16'h0010, 16'h00AA, 16'h00BB));
    tick(0);
    chk("rs_first", 80'({RS1, RS2}), 80'(8'h23));
    present(16'h2456, 16'h0012);
    sb.push_back(ex_of(16'h2456, 16'h0012, 16'h00AA, 16'h00BB));
    tick(1);
    chk("rs_second", 80'({RS1, RS2}), 80'(8'h56));
    IF_VALID = 0;
    tick(1);
    tick(0);
    // bypass hit on both operands
    REG_A = 16'h0000;
    REG_B = 16'h0000;
    WB_REGWRITE = 1;
    WB_RD = 4'd3;
    WB_DATA = 16'hBEEF;
    present(16'h1733, 16'h0020);
    sb.push_back(ex_of(16'h1733, 16'h0020, 16'hBEEF, 16'hBEEF));
    tick(0);
    IF_VALID = 0;
    tick(1);
    // writeback disabled
    WB_REGWRITE = 0;
    present(16'h2733, 16'h0022);
    sb.push_back(ex_of(16'h2733, 16'h0022, 16'h0000, 16'h0000));
    tick(0);
    IF_VALID = 0;
    tick(1);
    // bypass on rs1 only
    WB_REGWRITE = 1;
    REG_B = 16'h1234;
    present(16'h3734, 16'h0024);
    sb.push_back(ex_of(16'h3734, 16'h0024, 16'hBEEF, 16'h1234));
    tick(0);
    IF_VALID = 0;
    tick(1);
    WB_REGWRITE = 0;
    REG_A = 16'h00AA;
    REG_B = 16'h00BB;
    tick(0);
    // load-use hazard
    present(16'h8500, 16'h0040);
    sb.push_back(ex_of(16'h8500, 16'h0040, 16'h00AA, 16'h00BB));
    tick(0);
    present(16'h1652, 16'h0042);
    sb.push_back(ex_of(16'h1652, 16'h0042, 16'h00AA, 16'h00BB));
    tick(1);
    chk("lu_stall", 80'({STALL, IF_READY}), 80'(2'b10));
    present(16'h1612, 16'h0044);
    tick(0);
    chk("lu_release", 80'({STALL, IF_READY}), 80'(2'b01));
    sb.push_back(ex_of(16'h1612, 16'h0044, 16'h00AA, 16'h00BB));
    tick(1);
    IF_VALID = 0;
    tick(1);
    tick(0);
    // load with non-dependent follower
    present(16'h8500, 16'h0050);
    sb.push_back(ex_of(16'h8500, 16'h0050, 16'h00AA, 16'h00BB));
    tick(0);
    present(16'h1612, 16'h0052);
    sb.push_back(ex_of(16'h1612, 16'h0052, 16'h00AA, 16'h00BB));
    tick(1);
    chk("nodep_stall", 80'({STALL, IF_READY}), 80'(2'b01));
    IF_VALID = 0;
    tick(1);
    tick(0);
    // flush with ID and EX occupied
    present(16'h1123, 16'h0060);
    sb.push_back(ex_of(16'h1123, 16'h0060, 16'h00AA, 16'h00BB));
    tick(0);
    present(16'h2456, 16'h0062);
    tick(1);
    FLUSH = 1;
    present(16'h3789, 16'h0064);
    tick(0);
    FLUSH = 0;
    IF_VALID = 0;
    tick(0);
    tick(0);
    // flush during load-use stall
    present(16'h8500, 16'h0070);
    sb.push_back(ex_of(16'h8500, 16'h0070, 16'h00AA, 16'h00BB));
    tick(0);
    present(16'h1652, 16'h0072);
    tick(1);
    chk("fs_stall", 80'(STALL), 80'(1));
    FLUSH = 1;
    present(16'h1612, 16'h0074);
    tick(0);
    chk("fs_after", 80'({STALL, IF_READY}), 80'(2'b01));
    FLUSH = 0;
    sb.push_back(ex_of(16'h1612, 16'h0074, 16'h00AA, 16'h00BB));
    tick(0);
    IF_VALID = 0;
    tick(1);
    // immediate sign extension
    present(16'h9A80, 16'h0080);
    sb.push_back(ex_of(16'h9A80, 16'h0080, 16'h00AA, 16'h00BB));
    tick(0);
    present(16'h9A7F, 16'h0082);
    sb.push_back(ex_of(16'h9A7F, 16'h0082, 16'h00AA, 16'h00BB));
    tick(1);
    chk("imm_neg", 80'(EX_IMM), 80'(16'hFF80));
    IF_VALID = 0;
    tick(1);
    chk("imm_pos", 80'(EX_IMM), 80'(16'h007F));
    tick(0);
    // reset mid-stream
    present(16'h1123, 16'h0090);
    sb.push_back(ex_of(16'h1123, 16'h0090, 16'h00AA, 16'h00BB));
    tick(0);
    present(16'h8456, 16'h0092);
    tick(1);
    RST = 1;
    #1;
    chk("mrst_payload", ex_pl, 80'(0));
    chk("mrst_flags", 80'({EX_VALID, STALL, IF_READY}), 80'(3'b001));
    tick(0);
    tick(0);
    chk("mrst_hold", ex_pl, 80'(0));
    RST = 0;
    present(16'h4321, 16'h00A0);
    sb.push_back(ex_of(16'h4321, 16'h00A0, 16'h00AA, 16'h00BB));
    tick(0);
    IF_VALID = 0;
    tick(1);
    tick(0);
    chk("sb_leftover", 80'(sb.size()), 80'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
